// File: rtl/reg_file.sv
// General-purpose register file with two masked read buses, one write port and
// post-read signed auto-adjust on each read port (PC advance, SP push/pop).
module reg_file #(
    parameter int               WIDTH    = 32,
    parameter int               NUM_REGS = 16,
    parameter int               PC_IDX   = 15,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    localparam int              SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             ld,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             oe_a,
    input  logic             oe_b,
    input  logic [SEL_W-1:0] sel_a,
    input  logic [SEL_W-1:0] sel_b,
    input  logic [7:0]       count_a,
    input  logic [7:0]       count_b,
    input  logic [WIDTH-1:0] a_reg_mask,
    input  logic [WIDTH-1:0] b_reg_mask,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] pc
);

    localparam int SEL_SPAN = 2 ** SEL_W;

    // Read view padded to the full select range; unpopulated slots read as zero.
    logic [WIDTH-1:0] rd_val [SEL_SPAN];

    logic [WIDTH-1:0] adj_a;
    logic [WIDTH-1:0] adj_b;
    logic             cnt_a_en;
    logic             cnt_b_en;

    assign adj_a    = {{(WIDTH-8){count_a[7]}}, count_a};
    assign adj_b    = {{(WIDTH-8){count_b[7]}}, count_b};
    assign cnt_a_en = oe_a && (count_a != 8'd0);
    assign cnt_b_en = oe_b && (count_b != 8'd0);

    genvar gi;
    generate
        for (gi = 0; gi < SEL_SPAN; gi++) begin : g_reg
            if (gi < NUM_REGS) begin : g_live
                localparam logic [SEL_W-1:0] IDX     = SEL_W'(gi);
                localparam logic [WIDTH-1:0] RST_VAL = (gi == PC_IDX) ? RESET_PC : '0;

                logic [WIDTH-1:0] q_reg;
                logic [WIDTH-1:0] q_next;
                logic             hit_a;
                logic             hit_b;
                logic             hit_ld;

                assign hit_a  = cnt_a_en && (sel_a == IDX);
                assign hit_b  = cnt_b_en && (sel_b == IDX);
                assign hit_ld = ld && (sel_in == IDX);

                // A write wins over any adjust; both ports adjusting the same
                // register fold into a single sum.
                always_comb begin
                    q_next = q_reg;
                    if (hit_ld) begin
                        q_next = in;
                    end else begin
                        q_next = q_reg + (hit_a ? adj_a : '0) + (hit_b ? adj_b : '0);
                    end
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q_reg <= RST_VAL;
                    end else begin
                        q_reg <= q_next;
                    end
                end

                assign rd_val[gi] = q_reg;
            end else begin : g_empty
                assign rd_val[gi] = '0;
            end
        end
    endgenerate

    // Disabled buses drive zero so several sources can be OR-combined.
    assign out_a = oe_a ? (rd_val[sel_a] & a_reg_mask) : '0;
    assign out_b = oe_b ? (rd_val[sel_b] & b_reg_mask) : '0;
    assign pc    = rd_val[PC_IDX];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an array-based model.
module tb_reg_file;

    localparam int               WIDTH    = 32;
    localparam int               NUM_REGS = 16;
    localparam int               PC_IDX   = 15;
    localparam logic [WIDTH-1:0] RST_PC   = 32'h100;
    localparam logic [WIDTH-1:0] ONES     = '1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] din;
    logic             ld;
    logic [3:0]       sel_in;
    logic             oe_a;
    logic             oe_b;
    logic [3:0]       sel_a;
    logic [3:0]       sel_b;
    logic [7:0]       count_a;
    logic [7:0]       count_b;
    logic [WIDTH-1:0] a_reg_mask;
    logic [WIDTH-1:0] b_reg_mask;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] pc;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] model [NUM_REGS];

    reg_file #(
        .WIDTH   (WIDTH),
        .NUM_REGS(NUM_REGS),
        .PC_IDX  (PC_IDX),
        .RESET_PC(RST_PC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (din),
        .ld        (ld),
        .sel_in    (sel_in),
        .oe_a      (oe_a),
        .oe_b      (oe_b),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .count_a   (count_a),
        .count_b   (count_b),
        .a_reg_mask(a_reg_mask),
        .b_reg_mask(b_reg_mask),
        .out_a     (out_a),
        .out_b     (out_b),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registers as a plain array, updated per the precedence rules.
    always @(posedge clk or negedge rst_n) begin
        logic [WIDTH-1:0] nxt [NUM_REGS];
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) model[i] = (i == PC_IDX) ? RST_PC : '0;
        end else begin
            nxt = model;
            if (oe_a && count_a != 0) nxt[sel_a] = nxt[sel_a] + WIDTH'(int'($signed(count_a)));
            if (oe_b && count_b != 0) nxt[sel_b] = nxt[sel_b] + WIDTH'(int'($signed(count_b)));
            if (ld) nxt[sel_in] = din;
            model = nxt;
        end
    end

    // Every cycle, after the driver settles inputs, outputs must match the model.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            check("model_out_a", out_a, oe_a ? (model[sel_a] & a_reg_mask) : '0);
            check("model_out_b", out_b, oe_b ? (model[sel_b] & b_reg_mask) : '0);
            check("model_pc", pc, model[PC_IDX]);
        end
    end

    task automatic idle();
        ld = 0; din = '0; sel_in = 0;
        oe_a = 0; oe_b = 0; sel_a = 0; sel_b = 0;
        count_a = 0; count_b = 0;
        a_reg_mask = ONES; b_reg_mask = ONES;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic write_reg(input logic [3:0] r, input logic [WIDTH-1:0] v);
        step();
        ld = 1; sel_in = r; din = v;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_pc", pc, 32'h100);
        check("rst_out_a", out_a, '0);
        check("rst_out_b", out_b, '0);
        oe_a = 1; sel_a = 4'd7;
        #1;
        check("rst_r7", out_a, '0);
        #1;
        rst_n = 1'b1;

        // FETCH: PC read and advanced by one per cycle
        for (int i = 0; i < 3; i++) begin
            step();
            oe_b = 1; sel_b = 4'd15; count_b = 8'd1;
            #1;
            check("fetch_out_b", out_b, 32'h100 + WIDTH'(i));
            @(posedge clk);
            #1;
            check("fetch_pc", pc, 32'h101 + WIDTH'(i));
        end

        // Write then masked / unmasked read
        write_reg(4'd3, 32'hDEADBEEF);
        step();
        oe_a = 1; sel_a = 4'd3; a_reg_mask = 32'h0000FFFF;
        oe_b = 1; sel_b = 4'd3;
        #1;
        check("wr_masked_a", out_a, 32'h0000BEEF);
        check("wr_full_b", out_b, 32'hDEADBEEF);

        // Conflict: write beats count, then dual count on one register
        write_reg(4'd2, 32'd10);
        step();
        oe_a = 1; sel_a = 4'd2; count_a = 8'hFF;
        ld = 1; sel_in = 4'd2; din = 32'd50;
        #1;
        check("conf_pre", out_a, 32'd10);
        step();
        oe_a = 1; sel_a = 4'd2; count_a = 8'd4;
        oe_b = 1; sel_b = 4'd2; count_b = 8'hFF;
        #1;
        check("conf_ld_win", out_a, 32'd50);
        step();
        oe_a = 1; sel_a = 4'd2;
        #1;
        check("conf_dual", out_a, 32'd53);

        // Wrap both ways, and count ignored when oe low
        write_reg(4'd5, 32'hFFFFFFFF);
        write_reg(4'd6, 32'h0);
        step();
        oe_a = 1; sel_a = 4'd5; count_a = 8'd1;
        oe_b = 1; sel_b = 4'd6; count_b = 8'hFF;
        step();
        oe_a = 1; sel_a = 4'd5;
        oe_b = 1; sel_b = 4'd6;
        #1;
        check("wrap_up", out_a, 32'h0);
        check("wrap_down", out_b, 32'hFFFFFFFF);
        step();
        sel_a = 4'd6; count_a = 8'd5;
        step();
        oe_b = 1; sel_b = 4'd6;
        #1;
        check("oe_low_count", out_b, 32'hFFFFFFFF);

        // Disabled buses and zero masks
        step();
        sel_a = 4'd3; sel_b = 4'd6;
        #1;
        check("dis_a", out_a, '0);
        check("dis_b", out_b, '0);
        oe_a = 1; oe_b = 1; a_reg_mask = '0; b_reg_mask = '0;
        #1;
        check("mask0_a", out_a, '0);
        check("mask0_b", out_b, '0);

        // Asynchronous reset between edges
        step();
        oe_a = 1; sel_a = 4'd3;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_pc", pc, 32'h100);
        check("async_r3", out_a, '0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 2000; n++) begin
            step();
            ld      = ($urandom_range(0, 2) == 0);
            sel_in  = 4'($urandom_range(0, 15));
            din     = ($urandom_range(0, 7) == 0) ? ONES : $urandom;
            oe_a    = $urandom_range(0, 1) == 1;
            oe_b    = $urandom_range(0, 1) == 1;
            sel_a   = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            sel_b   = ($urandom_range(0, 3) == 0) ? sel_a : 4'($urandom_range(0, 15));
            count_a = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
            count_b = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
            a_reg_mask = ($urandom_range(0, 1) == 1) ? ONES : $urandom;
            b_reg_mask = ($urandom_range(0, 1) == 1) ? ONES : $urandom;
        end

        step();
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- General-purpose register file sitting directly downstream of the CPU control unit. It consumes that unit's A/B select, output-enable, load, post-increment count and mask signals.
- Drives two operand buses (A, B) and accepts one write bus.
- Provides auto-increment/decrement on read, used for PC advance in FETCH and SP push/pop.
- Holds architectural state only; no memory or ALU logic.

Parameters:
- WIDTH, 32, data width of every register and bus.
- NUM_REGS, 16, register count; selects are $clog2(NUM_REGS) bits (4 at default, matching reg_e).
- PC_IDX, 15, index of the program counter within the file.
- RESET_PC, 32'h0, PC value after reset.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  WIDTH  write data bus.
- ld  input  1  write enable for register sel_in.
- sel_in  input  4  write register index.
- oe_a  input  1  drive out_a.
- oe_b  input  1  drive out_b.
- sel_a  input  4  A read index.
- sel_b  input  4  B read index.
- count_a  input  8  signed post-read adjust for register sel_a.
- count_b  input  8  signed post-read adjust for register sel_b.
- a_reg_mask  input  WIDTH  AND-mask applied to out_a.
- b_reg_mask  input  WIDTH  AND-mask applied to out_b.
- out_a  output  WIDTH  A bus.
- out_b  output  WIDTH  B bus.
- pc  output  WIDTH  current PC value, debug/observe.

Behaviour:
- Reset (rst_n low, asynchronous): all registers become 0 except regs[PC_IDX] = RESET_PC. Outputs follow combinationally, so out_a = out_b = 0 with oe low and pc = RESET_PC. Reset released synchronously-safe; the first update occurs on the first posedge after deassertion.
- Reads are combinational, zero latency:
  - out_a = oe_a ? (regs[sel_a] & a_reg_mask) : 0.
  - out_b = oe_b ? (regs[sel_b] & b_reg_mask) : 0.
  - Buses are zero (not Z) when disabled, so they can be OR-combined.
- Read value is always the pre-update register content. No write-through bypass: a value written on edge N is visible on out_* after edge N.
- Counting happens on posedge. If oe_a=1 and count_a!=0, regs[sel_a] <= regs[sel_a] + sext(count_a). Port B behaves the same with count_b. Count is ignored when the matching oe is 0.
- Arithmetic is modulo 2^WIDTH: 0xFFFFFFFF+1 -> 0, 0-1 -> 0xFFFFFFFF. Masks do not affect the count source; the full unmasked register value is used.
- Write: if ld=1, regs[sel_in] <= in on posedge.
- Simultaneous-event precedence, resolved per register:
  - ld to register R overrides any count targeting R in the same cycle (written value = in, no adjust).
  - sel_a==sel_b with both counting: R <= R + sext(count_a) + sext(count_b), one update.
  - ld to R plus counting on a different register S: both take effect.
- Reset asserted mid-cycle overrides ld and counts immediately.
- Out-of-range indices (NUM_REGS not a power of two): reads return 0, writes and counts are dropped.
- pc = regs[PC_IDX], unmasked, unaffected by oe.

Test Plan:
- Reset: hold rst_n=0 with RESET_PC=32'h100 -> pc=0x100, regs[0..14]=0, out_a=out_b=0. Assert rst_n low asynchronously between edges -> immediate clear.
- FETCH pattern: oe_b=1, sel_b=15, count_b=1, pc=0x100 -> out_b=0x100 in the same cycle; after the edge pc=0x101. Repeat 3 cycles -> 0x103.
- Write then read: ld=1, sel_in=3, in=0xDEADBEEF; next cycle oe_a=1, sel_a=3, a_reg_mask=0x0000FFFF -> out_a=0x0000BEEF, oe_b with full mask reads 0xDEADBEEF.
- Conflict: r2=10, oe_a=1, sel_a=2, count_a=-1, ld=1, sel_in=2, in=50 -> r2=50. Then sel_a=sel_b=2, count_a=+4, count_b=-1 -> r2=53.
- Wrap: r5=0xFFFFFFFF, count_a=+1 -> 0; r6=0, count_b=-1 (8'hFF) -> 0xFFFFFFFF. Count with oe low -> unchanged.
- Disabled buses: oe_a=oe_b=0 with nonzero regs -> out_a=out_b=0; masks 0 with oe=1 -> 0.
